param_serial_transmitter: RTL

- Parametrised successor to the lab serial transmitter.
- Hunts for a configurable start pattern on serIn, reads a LEN_W-bit length field (MSB first), then forwards exactly that many payload bits to serOut with per-bit valid strobes and a live remaining-count output (countOut, feeds the SSD driver).
- STEP_MODE selects the bit-advance source: push-button single-step via an internal pulser, or free-running every clk.
- Adds done/busy status.

---
 rtl/param_serial_transmitter_pkg.sv | 20 ++
 rtl/param_serial_transmitter_step_pulse_gen.sv | 29 ++
 rtl/param_serial_transmitter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/param_serial_transmitter_pkg.sv
// Shared types and defaults for the parameterised serial transmitter.
// Holds the frame FSM states and the sizing helper for the length-bit counter.
package param_serial_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_LEN_W   = 4;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_serial_transmitter_step_pulse_gen.sv
// Button synchroniser plus rising-edge detector: one clk-wide step per press.
// step_o rises two clk edges after btn_i is first sampled high; re-arms once btn_i is seen low.
// No backpressure; a held button yields a single pulse.
module step_pulse_gen (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic step_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign step_o = sync2_q & ~prev_q;

endmodule

// File: rtl/param_serial_transmitter.sv
// Pattern-triggered serial forwarder: hunt PATTERN, read LEN_W-bit length, forward that many bits.
// serOut/serOutValid appear 1 clk after the step edge that samples the payload bit; no backpressure.
module param_serial_transmitter
    import param_serial_transmitter_pkg::*;
#(
    parameter int                 PAT_LEN   = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN   = DEF_PATTERN,
    parameter int                 LEN_W     = DEF_LEN_W,
    parameter int                 STEP_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkPB,
    input  logic             serIn,
    output logic             serOut,
    output logic             serOutValid,
    output logic [LEN_W-1:0] countOut,
    output logic             busy,
    output logic             done
);

    localparam int               BCW      = cnt_w(LEN_W);
    localparam logic [BCW-1:0]   LEN_LAST = BCW'(LEN_W - 1);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

    logic step;

    generate
        if (STEP_MODE == 1) begin : g_pb
            step_pulse_gen u_step (
                .clk    (clk),
                .rst    (rst),
                .btn_i  (clkPB),
                .step_o (step)
            );
        end else begin : g_free
            logic unused_pb;
            assign unused_pb = clkPB;
            assign step      = 1'b1;
        end
    endgenerate

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [BCW-1:0]     bcnt_q, bcnt_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ser_q, ser_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;

    logic [PAT_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   len_nxt;

    assign hist_nxt = PAT_LEN'({hist_q, serIn});
    assign len_nxt  = LEN_W'({len_q, serIn});

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        if (step) begin
            case (state_q)
                ST_IDLE: begin
                    hist_d = hist_nxt;
                    if (hist_nxt == PATTERN) begin
                        state_d = ST_LEN;
                        hist_d  = '0;
                        len_d   = '0;
                        bcnt_d  = '0;
                    end
                end
                ST_LEN: begin
                    len_d  = len_nxt;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == LEN_LAST) begin
                        bcnt_d = '0;
                        len_d  = '0;
                        if (len_nxt != '0) begin
                            cnt_d   = len_nxt;
                            state_d = ST_DATA;
                        end else begin
                            // Empty frame: close it without any payload strobe.
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    ser_d = serIn;
                    vld_d = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign serOut      = ser_q;
    assign serOutValid = vld_q;
    assign countOut    = cnt_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule
